// File: rtl/adder_sum_collector.sv
// adder_sum_collector: capture stage for the adder's sum output.
// Accepted sums are queued in a small FIFO, which is drained through a
// valid/ready port. Each accepted sum is also added into a running
// accumulator that has a sticky wrap flag. Every output is either a register
// or a function of registered state only, so no input has a combinational
// path to an output.
module adder_sum_collector #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH:0]        x_in,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH:0]        out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [ACC_WIDTH-1:0]       acc,
  output logic                       acc_ovf
);

  localparam int SUM_W = DATA_WIDTH + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [SUM_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;
  logic [ACC_WIDTH:0] acc_sum;

  // Handshake flags are decoded from the registered occupancy only. This
  // means a pop on a full FIFO cannot open the input in the same cycle.
  assign in_ready  = (level != LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // The head of the FIFO is forced to zero when empty, so stale storage
  // never appears on the output.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // The sum is one bit wider than the accumulator, and the top bit is the
  // wrap carry.
  assign acc_sum   = {1'b0, acc} + (ACC_WIDTH + 1)'(x_in);

  // Storage write on push.
  // NOTE: the data array has no reset. Out-of-range entries are masked by
  // level, so a reset here would only add fan-out to every storage flop.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= x_in;
  end

  // Pointer and occupancy bookkeeping. The pointers wrap modulo DEPTH.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every branch reads the pre-edge values of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Accumulator with sticky wrap flag. When clear and a push happen in the
  // same cycle, the pushed sample becomes the first term of the new sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (clear && push) begin
      acc     <= ACC_WIDTH'(x_in);
      acc_ovf <= 1'b0;
    end else if (clear) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (push) begin
      acc     <= acc_sum[ACC_WIDTH-1:0];
      acc_ovf <= acc_ovf | acc_sum[ACC_WIDTH];
    end
  end

endmodule

// File: tb/tb_adder_sum_collector.sv
// Directed and streaming bench for adder_sum_collector (default parameters).
module tb_adder_sum_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] x_in;
  logic       clear;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic [2:0] level;
  logic [7:0] acc;
  logic       acc_ovf;

  int vectors     = 0;
  int miscompares = 0;

  adder_sum_collector #(.DATA_WIDTH(4), .ACC_WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .acc       (acc),
    .acc_ovf   (acc_ovf)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then move 1 time unit past it. Both sampling
  // and driving happen at that point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] x, input logic r, input logic c);
    in_valid  = v;
    x_in      = x;
    out_ready = r;
    clear     = c;
  endtask

  // Status word is {in_ready, out_valid, level, acc, acc_ovf, out_data}.
  task automatic test_reset();
    logic [18:0] exp_w;
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    repeat (2) tick();
    exp_w = {1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 5'd0};
    vectors++;
    if ({in_ready, out_valid, level, acc, acc_ovf, out_data} !== exp_w) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected %h",
               {in_ready, out_valid, level, acc, acc_ovf, out_data}, exp_w);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if ({in_ready, out_valid, level, acc, acc_ovf, out_data} !== exp_w) begin
      miscompares++;
      $display("FAIL reset_idle: got %h expected %h",
               {in_ready, out_valid, level, acc, acc_ovf, out_data}, exp_w);
    end
  endtask

  task automatic test_ordering();
    logic [4:0] vals [4];
    vals[0] = 5'd3; vals[1] = 5'd30; vals[2] = 5'd0; vals[3] = 5'd17;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i], 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 5'd31, 1'b0, 1'b0);
    vectors++;
    if ({level, in_ready, acc, out_valid} !== {3'd4, 1'b0, 8'd50, 1'b1}) begin
      miscompares++;
      $display("FAIL order_fill: got level=%0d in_ready=%b acc=%0d out_valid=%b expected 4 0 50 1",
               level, in_ready, acc, out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({out_valid, out_data} !== {1'b1, vals[i]}) begin
        miscompares++;
        $display("FAIL order_drain[%0d]: got valid=%b data=%0d expected 1 %0d",
                 i, out_valid, out_data, vals[i]);
      end
      tick();
    end
    vectors++;
    if ({out_valid, out_data, level, acc} !== {1'b0, 5'd0, 3'd0, 8'd50}) begin
      miscompares++;
      $display("FAIL order_empty: got valid=%b data=%0d level=%0d acc=%0d expected 0 0 0 50",
               out_valid, out_data, level, acc);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_boundary();
    // Fill with 1..4 (acc 50 -> 60), then offer 9 while popping.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    drive(1'b0, 5'd0, 1'b1, 1'b0);
    vectors++;
    if ({level, in_ready, acc, out_data} !== {3'd3, 1'b1, 8'd60, 5'd2}) begin
      miscompares++;
      $display("FAIL full_pop: got level=%0d in_ready=%b acc=%0d head=%0d expected 3 1 60 2",
               level, in_ready, acc, out_data);
    end
    for (int i = 2; i <= 4; i++) begin
      vectors++;
      if ({out_valid, out_data} !== {1'b1, 5'(i)}) begin
        miscompares++;
        $display("FAIL full_drain[%0d]: got valid=%b data=%0d expected 1 %0d",
                 i, out_valid, out_data, i);
      end
      tick();
    end
    vectors++;
    if ({out_valid, level} !== {1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL full_no9: got valid=%b level=%0d expected 0 0", out_valid, level);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] exp_acc;
    drive(1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    vectors++;
    if ({acc, acc_ovf} !== {8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL ovf_clear: got acc=%0d ovf=%b expected 0 0", acc, acc_ovf);
    end
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, 5'd30, 1'b1, 1'b0);
      tick();
      exp_acc = 8'((30 * k) % 256);
      vectors++;
      if ({acc, acc_ovf} !== {exp_acc, (k == 9)}) begin
        miscompares++;
        $display("FAIL ovf_push[%0d]: got acc=%0d ovf=%b expected %0d %b",
                 k, acc, acc_ovf, exp_acc, (k == 9));
      end
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 5'd0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    vectors++;
    if ({acc, acc_ovf, level} !== {8'd14, 1'b1, 3'd0}) begin
      miscompares++;
      $display("FAIL ovf_sticky: got acc=%0d ovf=%b level=%0d expected 14 1 0",
               acc, acc_ovf, level);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_clear();
    // The accumulator holds 14 with the wrap flag set. Pushing 30 and 6 brings it to 50.
    drive(1'b1, 5'd30, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd6,  1'b0, 1'b0); tick();
    vectors++;
    if ({acc, acc_ovf, level} !== {8'd50, 1'b1, 3'd2}) begin
      miscompares++;
      $display("FAIL clr_setup: got acc=%0d ovf=%b level=%0d expected 50 1 2", acc, acc_ovf, level);
    end
    drive(1'b1, 5'd5, 1'b0, 1'b1); tick();
    vectors++;
    if ({acc, acc_ovf, level} !== {8'd5, 1'b0, 3'd3}) begin
      miscompares++;
      $display("FAIL clr_push: got acc=%0d ovf=%b level=%0d expected 5 0 3", acc, acc_ovf, level);
    end
    drive(1'b0, 5'd0, 1'b0, 1'b1); tick();
    clear = 1'b0;
    vectors++;
    if ({acc, acc_ovf, level, out_data} !== {8'd0, 1'b0, 3'd3, 5'd30}) begin
      miscompares++;
      $display("FAIL clr_alone: got acc=%0d ovf=%b level=%0d head=%0d expected 0 0 3 30",
               acc, acc_ovf, level, out_data);
    end
  endtask

  task automatic test_midstream_reset();
    // The FIFO holds three entries at this point.
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, level, acc, acc_ovf, out_data} !==
        {1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_async: got %h expected %h",
               {in_ready, out_valid, level, acc, acc_ovf, out_data},
               {1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 5'd0});
    end
    tick();
    rst_n = 1'b1;
    drive(1'b1, 5'd7, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    vectors++;
    if ({level, acc, out_valid, out_data} !== {3'd1, 8'd7, 1'b1, 5'd7}) begin
      miscompares++;
      $display("FAIL reset_first_push: got level=%0d acc=%0d valid=%b data=%0d expected 1 7 1 7",
               level, acc, out_valid, out_data);
    end
  endtask

  task automatic test_streaming();
    logic [4:0] q[$];
    logic [7:0] acc_m;
    logic [4:0] exp_head;
    logic       do_push;
    logic       do_pop;
    int         stream_errs;
    stream_errs = 0;
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    acc_m = 8'd0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      exp_head = (q.size() != 0) ? q[0] : 5'd0;
      vectors++;
      if ({out_valid, out_data, level, in_ready, acc} !==
          {(q.size() != 0), exp_head, 3'(q.size()), (q.size() != 4), acc_m}) begin
        miscompares++;
        if (stream_errs < 10)
          $display("FAIL stream[%0d]: got valid=%b data=%0d level=%0d in_ready=%b acc=%0d expected %b %0d %0d %b %0d",
                   cyc, out_valid, out_data, level, in_ready, acc,
                   (q.size() != 0), exp_head, q.size(), (q.size() != 4), acc_m);
        stream_errs++;
      end
      vectors++;
      if (level > 3'd4) begin
        miscompares++;
        $display("FAIL stream_level_range[%0d]: got %0d expected at most 4", cyc, level);
      end
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 30)),
            1'($urandom_range(0, 1)), 1'b0);
      do_push = in_valid && (q.size() < 4);
      do_pop  = out_ready && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(x_in);
        acc_m = acc_m + 8'(x_in);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    test_reset();
    test_ordering();
    test_full_boundary();
    test_overflow();
    test_clear();
    test_midstream_reset();
    test_streaming();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
